// File: rtl/level_map_ctrl.sv
`default_nettype none
// level_map_ctrl: 15x20 wall-tile working map loaded row by row from one of four static levels,
// with per-tile shot clearing and a registered pixel lookup. Optional macro: LEVEL_MAP_HIT_COUNT_EN.
module level_map_ctrl #(
   parameter logic [7:0] WALL_COLOR = 8'hE0,
   parameter int         TILE_SHIFT = 5
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic [0:14][0:19]  mat_in0,
   input  logic [0:14][0:19]  mat_in1,
   input  logic [0:14][0:19]  mat_in2,
   input  logic [0:14][0:19]  mat_in3,
   input  logic [1:0]         level_sel,
   input  logic               load_level,
   input  logic [10:0]        pixelX,
   input  logic [10:0]        pixelY,
   input  logic               hit_valid,
   input  logic [4:0]         hit_col,
   input  logic [3:0]         hit_row,
   output logic               drawingRequest,
   output logic [7:0]         RGBout,
   output logic               level_ready,
   output logic               hit_ack,
   output logic               hit_wall
`ifdef LEVEL_MAP_HIT_COUNT_EN
   ,
   output logic [8:0]         bricks_destroyed
`endif
);

   localparam logic [3:0] LAST_ROW = 4'd14;
   localparam logic [4:0] LAST_COL = 5'd19;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          sel_q;
   logic [3:0]          row_q;
   logic [0:14][0:19]   map_q;
   logic                drawing_q, drawing_d;
   logic                ack_q, ack_d;
   logic                wall_q, wall_d;

   logic                load_start;
   logic                hit_bit;
   logic [0:19]         src_row;
   logic [10:0]         tile_col;
   logic [10:0]         tile_row;
   logic                tile_in_range;

   // A load request is only honoured outside LOAD; it also pre-empts any same-cycle hit.
   assign load_start    = load_level && (state_q != LOAD);
   assign hit_bit       = map_q[hit_row][hit_col];
   assign ack_d         = hit_valid && (state_q == ACTIVE) && !load_level &&
                          (hit_row <= LAST_ROW) && (hit_col <= LAST_COL);
   assign wall_d        = ack_d && hit_bit;

   assign tile_col      = pixelX >> TILE_SHIFT;
   assign tile_row      = pixelY >> TILE_SHIFT;
   assign tile_in_range = (tile_col < 11'd20) && (tile_row < 11'd15);
   assign drawing_d     = level_ready && tile_in_range &&
                          map_q[tile_row[3:0]][tile_col[4:0]];

   always_comb begin
      src_row = '0;
      case (sel_q)
         2'd0: src_row = mat_in0[row_q];
         2'd1: src_row = mat_in1[row_q];
         2'd2: src_row = mat_in2[row_q];
         2'd3: src_row = mat_in3[row_q];
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (load_level) state_d = LOAD;
         LOAD:    if (row_q == LAST_ROW) state_d = ACTIVE;
         ACTIVE:  if (load_level) state_d = LOAD;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         row_q     <= '0;
         map_q     <= '0;
         drawing_q <= 1'b0;
         ack_q     <= 1'b0;
         wall_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         drawing_q <= drawing_d;
         ack_q     <= ack_d;
         wall_q    <= wall_d;
         if (load_start) begin
            sel_q <= level_sel;
            row_q <= '0;
         end else if (state_q == LOAD) begin
            map_q[row_q] <= src_row;
            row_q        <= (row_q == LAST_ROW) ? 4'd0 : row_q + 4'd1;
         end
         // Hits are only accepted in ACTIVE, so they never collide with a row copy.
         if (ack_d) begin
            map_q[hit_row][hit_col] <= 1'b0;
         end
      end
   end

`ifdef LEVEL_MAP_HIT_COUNT_EN
   logic [8:0] bricks_q;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         bricks_q <= '0;
      end else if (load_start) begin
         bricks_q <= '0;
      end else if (wall_d && (bricks_q != 9'd300)) begin
         bricks_q <= bricks_q + 9'd1;
      end
   end

   assign bricks_destroyed = bricks_q;
`endif

   assign drawingRequest = drawing_q;
   assign RGBout         = WALL_COLOR;
   assign level_ready    = (state_q == ACTIVE);
   assign hit_ack        = ack_q;
   assign hit_wall       = wall_q;

endmodule
`default_nettype wire

// File: tb/tb_level_map_ctrl.sv
`default_nettype none
// tb_level_map_ctrl: randomized bench comparing level_map_ctrl against a tile-array reference model.
module tb_level_map_ctrl;

   logic              clk;
   logic              resetN;
   logic [0:14][0:19] mat [0:3];
   logic [1:0]        level_sel;
   logic              load_level;
   logic [10:0]       pixelX;
   logic [10:0]       pixelY;
   logic              hit_valid;
   logic [4:0]        hit_col;
   logic [3:0]        hit_row;
   logic              drawingRequest;
   logic [7:0]        RGBout;
   logic              level_ready;
   logic              hit_ack;
   logic              hit_wall;
`ifdef LEVEL_MAP_HIT_COUNT_EN
   logic [8:0]        bricks_destroyed;
`endif

   level_map_ctrl #(.WALL_COLOR(8'hE0), .TILE_SHIFT(5)) dut (
      .clk            (clk),
      .resetN         (resetN),
      .mat_in0        (mat[0]),
      .mat_in1        (mat[1]),
      .mat_in2        (mat[2]),
      .mat_in3        (mat[3]),
      .level_sel      (level_sel),
      .load_level     (load_level),
      .pixelX         (pixelX),
      .pixelY         (pixelY),
      .hit_valid      (hit_valid),
      .hit_col        (hit_col),
      .hit_row        (hit_row),
      .drawingRequest (drawingRequest),
      .RGBout         (RGBout),
      .level_ready    (level_ready),
      .hit_ack        (hit_ack),
      .hit_wall       (hit_wall)
`ifdef LEVEL_MAP_HIT_COUNT_EN
      ,
      .bricks_destroyed (bricks_destroyed)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: tile array, ready flag and wall-hit count.
   bit ref_map [0:14][0:19];
   bit ref_ready;
   int ref_bricks;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit exp_draw(input int px, input int py);
      int c, r;
      c = px / 32;
      r = py / 32;
      if (!ref_ready || c >= 20 || r >= 15) return 1'b0;
      return ref_map[r][c];
   endfunction

   task automatic ref_load(input int sel);
      logic [0:14][0:19] m;
      m = mat[sel];
      for (int r = 0; r < 15; r++)
         for (int c = 0; c < 20; c++)
            ref_map[r][c] = m[r][c];
      ref_bricks = 0;
   endtask

   task automatic chk_bricks(input string tag);
`ifdef LEVEL_MAP_HIT_COUNT_EN
      chk(tag, 32'(bricks_destroyed), 32'(ref_bricks));
`endif
   endtask

   // Pulse load_level and expect ready exactly 16 cycles after the pulse cycle.
   // With inject set, a second load and a hit are issued mid-load and must be ignored.
   task automatic do_load(input int sel, input bit inject);
      level_sel  = 2'(sel);
      load_level = 1'b1;
      tick();
      load_level = 1'b0;
      level_sel  = 2'(3 - sel);
      ref_ready  = 1'b0;
      chk("load_ready_drop", 32'(level_ready), 32'd0);
      for (int k = 1; k <= 15; k++) begin
         load_level = inject && (k == 3);
         hit_valid  = inject && (k == 5);
         hit_row    = 4'd2;
         hit_col    = 5'd5;
         tick();
         if (k == 15 || k == 14) chk("load_ready", 32'(level_ready), 32'(k == 15));
         if (inject && k == 6) chk("load_hit_drop", 32'(hit_ack), 32'd0);
      end
      load_level = 1'b0;
      hit_valid  = 1'b0;
      ref_load(sel);
      ref_ready = 1'b1;
      chk_bricks("bricks_after_load");
   endtask

   // Lookup every tile once at a random pixel inside it.
   task automatic scan_map(input string tag);
      int errs_before;
      errs_before = n_errors;
      for (int r = 0; r < 15; r++) begin
         for (int c = 0; c < 20; c++) begin
            pixelX = 11'(c * 32 + $urandom_range(0, 31));
            pixelY = 11'(r * 32 + $urandom_range(0, 31));
            tick();
            chk(tag, 32'(drawingRequest), 32'(exp_draw(int'(pixelX), int'(pixelY))));
            if (n_errors > errs_before + 4) return;
         end
      end
   endtask

   task automatic one_hit(input int r, input int c, input string tag);
      bit acc, ew;
      acc = (r < 15) && (c < 20) && ref_ready;
      ew  = acc ? ref_map[r][c] : 1'b0;
      hit_valid = 1'b1;
      hit_row   = 4'(r);
      hit_col   = 5'(c);
      tick();
      hit_valid = 1'b0;
      chk({tag, "_ack"}, 32'(hit_ack), 32'(acc));
      if (acc) begin
         chk({tag, "_wall"}, 32'(hit_wall), 32'(ew));
         ref_map[r][c] = 1'b0;
         if (ew) ref_bricks++;
      end
      chk_bricks({tag, "_bricks"});
   endtask

   initial begin
      for (int m = 0; m < 4; m++)
         for (int r = 0; r < 15; r++)
            for (int c = 0; c < 20; c++)
               mat[m][r][c] = 1'($urandom_range(0, 1));
      mat[3][2][5] = 1'b1;
      mat[1][0][0] = 1'b1;
      mat[1][0][1] = 1'b1;
      mat[1][0][2] = 1'b1;
      mat[1][0][3] = 1'b0;
      resetN     = 1'b0;
      level_sel  = 2'd0;
      load_level = 1'b0;
      pixelX     = 11'd160;
      pixelY     = 11'd64;
      hit_valid  = 1'b0;
      hit_row    = 4'd0;
      hit_col    = 5'd0;
      ref_ready  = 1'b0;
      ref_bricks = 0;
      for (int r = 0; r < 15; r++)
         for (int c = 0; c < 20; c++)
            ref_map[r][c] = 1'b0;

      tick();
      chk("rst_ready", 32'(level_ready), 32'd0);
      chk("rst_draw",  32'(drawingRequest), 32'd0);
      chk("rst_ack",   32'(hit_ack), 32'd0);
      chk("rst_wall",  32'(hit_wall), 32'd0);
      chk("rgb",       32'(RGBout), 32'hE0);
      chk_bricks("rst_bricks");
      tick();
      resetN = 1'b1;

      // Idle: nothing ready, hits dropped.
      tick();
      chk("idle_ready", 32'(level_ready), 32'd0);
      one_hit(2, 5, "idle_hit");
      tick();
      chk("idle_draw", 32'(drawingRequest), 32'd0);

      do_load(3, 1'b1);
      scan_map("map3");

      pixelX = 11'd160;
      pixelY = 11'd64;
      tick();
      chk("tile_2_5_wall", 32'(drawingRequest), 32'd1);
      one_hit(2, 5, "hit_2_5");
      tick();
      chk("tile_2_5_cleared", 32'(drawingRequest), 32'd0);
      one_hit(2, 5, "rehit_2_5");
      pixelX = 11'd700;
      tick();
      chk("px700", 32'(drawingRequest), 32'd0);
      pixelX = 11'd100;
      pixelY = 11'd480;
      tick();
      chk("py480", 32'(drawingRequest), 32'd0);
      one_hit(15, 3, "row15");
      one_hit(4, 20, "col20");

      // Random hits interleaved with random lookups.
      for (int i = 0; i < 300; i++) begin
         int  hr, hc, px, py;
         bit  hv, acc, ew, ed;
         hr = $urandom_range(0, 15);
         hc = $urandom_range(0, 21);
         hv = 1'($urandom_range(0, 1));
         px = $urandom_range(0, 700);
         py = $urandom_range(0, 520);
         hit_valid = hv;
         hit_row   = 4'(hr);
         hit_col   = 5'(hc);
         pixelX    = 11'(px);
         pixelY    = 11'(py);
         acc = hv && hr < 15 && hc < 20;
         ew  = acc ? ref_map[hr][hc] : 1'b0;
         ed  = exp_draw(px, py);
         tick();
         chk("rnd_ack",  32'(hit_ack), 32'(acc));
         chk("rnd_wall", 32'(hit_wall), 32'(ew));
         chk("rnd_draw", 32'(drawingRequest), 32'(ed));
         if (acc) begin
            ref_map[hr][hc] = 1'b0;
            if (ew) ref_bricks++;
         end
         chk_bricks("rnd_bricks");
      end
      hit_valid = 1'b0;
      scan_map("map3_after_hits");

      // Load coinciding with a hit: load wins.
      hit_valid  = 1'b1;
      hit_row    = 4'd0;
      hit_col    = 5'd0;
      do_load(1, 1'b0);
      chk("ready_after_reload", 32'(level_ready), 32'd1);
      scan_map("map1");
      one_hit(0, 0, "cnt_a");
      one_hit(0, 1, "cnt_b");
      one_hit(0, 2, "cnt_c");
      one_hit(0, 3, "cnt_empty");
      chk("cnt_ref", 32'(ref_bricks), 32'd3);
      do_load(0, 1'b0);

      // Reset partway through a load.
      level_sel  = 2'd2;
      load_level = 1'b1;
      tick();
      load_level = 1'b0;
      ref_ready  = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      #2;
      resetN = 1'b0;
      #1;
      chk("midrst_ready", 32'(level_ready), 32'd0);
      chk("midrst_draw",  32'(drawingRequest), 32'd0);
      chk("midrst_ack",   32'(hit_ack), 32'd0);
      chk("midrst_wall",  32'(hit_wall), 32'd0);
      ref_bricks = 0;
      chk_bricks("midrst_bricks");
      tick();
      resetN = 1'b1;
      for (int k = 0; k < 20; k++) begin
         pixelX = 11'($urandom_range(0, 639));
         pixelY = 11'($urandom_range(0, 479));
         tick();
         chk("post_rst_ready", 32'(level_ready), 32'd0);
         chk("post_rst_draw",  32'(drawingRequest), 32'd0);
      end
      do_load(2, 1'b0);
      scan_map("map2");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/level_map_ctrl.md
LEVEL_MAP_CTRL -- requirements
Module: level_map_ctrl

Interface
REQ-001 Parameter WALL_COLOR, 8'hE0, RGB332 colour driven on RGBout for wall tiles.
REQ-002 Parameter TILE_SHIFT, 5, log2 of tile edge in pixels (32x32 tiles cover 640x480).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 resetN  input  1  asynchronous, active-low reset.
REQ-005 mat_in0..mat_in3  input  [0:14][0:19] each  four static level maps; 1 = wall, [row][col].
REQ-006 level_sel  input  2  level index sampled on load_level.
REQ-007 load_level  input  1  single-cycle pulse requesting a level load.
REQ-008 pixelX / pixelY  input  11 each  current VGA pixel coordinate.
REQ-009 hit_valid  input  1  shot-impact request, one cycle.
REQ-010 hit_col / hit_row  input  5 / 4  tile addressed by hit_valid.
REQ-011 drawingRequest  output  1  current pixel lies on a wall tile.
REQ-012 RGBout  output  8  pixel colour, always WALL_COLOR.
REQ-013 level_ready  output  1  working map valid, hits accepted.
REQ-014 hit_ack  output  1  one-cycle pulse answering each accepted hit.
REQ-015 hit_wall  output  1  qualified by hit_ack: addressed tile was a wall before the hit.

Function
REQ-016 Block SHALL hold a 15x20 working map register and an FSM with states IDLE, LOAD, ACTIVE.
REQ-017 IDLE: level_ready=0; load_level moves to LOAD and latches level_sel.
REQ-018 LOAD SHALL copy one row per cycle from the latched mat_inN, rows 0..14 via 4-bit row counter; exactly 15 cycles, then ACTIVE.
REQ-019 ACTIVE: level_ready=1; load_level SHALL restart LOAD (level_ready drops the next cycle, working map rewritten).
REQ-020 load_level during LOAD SHALL be ignored.
REQ-021 hit_valid in ACTIVE with hit_row<=14 and hit_col<=19 SHALL clear that bit and assert hit_ack one cycle later with hit_wall = previous bit value.
REQ-022 hit_valid outside ACTIVE or out of range SHALL be dropped: no map change, hit_ack=0.
REQ-023 hit_valid coinciding with load_level in ACTIVE: load wins, hit dropped.
REQ-024 Tile lookup: col = pixelX>>TILE_SHIFT, row = pixelY>>TILE_SHIFT; out-of-range coordinates give drawingRequest=0.
REQ-025 drawingRequest SHALL be registered: one-cycle latency from pixelX/pixelY, and 0 whenever level_ready was 0 on the sampling edge.
REQ-026 Hit cleared on edge N SHALL be visible to a lookup sampled on edge N+1.

Reset
REQ-027 resetN low SHALL immediately force: FSM=IDLE, working map all 0, row counter 0, drawingRequest=0, level_ready=0, hit_ack=0, hit_wall=0.
REQ-028 Reset mid-LOAD SHALL abort the load; no automatic reload after release.

Configuration
REQ-029 Macro LEVEL_MAP_HIT_COUNT_EN defined: add output bricks_destroyed[8:0], incremented on each hit_ack with hit_wall=1, cleared on reset and on LOAD entry, saturating at 300.
REQ-030 Macro undefined: port and counter absent; all other behaviour identical.

Verification
REQ-031 Reset, load_level with level_sel=3 -> level_ready rises exactly 16 cycles after pulse; map equals mat_in3 bit-for-bit.
REQ-032 ACTIVE on map with wall at row 2 col 5, hit_valid row 2 col 5 -> next cycle hit_ack=1, hit_wall=1; repeat -> hit_ack=1, hit_wall=0.
REQ-033 pixelX=160, pixelY=64 on wall tile (row 2, col 5) -> drawingRequest=1 one cycle later; after hit -> 0; pixelX=700 -> 0.
REQ-034 hit_valid row 15 or col 20, or during LOAD -> hit_ack stays 0, map unchanged.
REQ-035 resetN pulsed low at LOAD row 7 -> all outputs 0 at once, FSM IDLE, level_ready stays 0 until a new load_level.
REQ-036 With LEVEL_MAP_HIT_COUNT_EN: three wall hits then one empty hit -> bricks_destroyed=3; load_level -> 0.
